id_ex_reg: RTL

ID/EX pipeline register for the five-stage MIPS core, with the EX-stage forwarding select generator. It captures the decoded instruction bundle from ID on each rising edge and presents it to EX. It also produces the 2-bit selects that drive the EX-stage 4:1 32-bit operand muxes, which choose between the latched register value, the MEM result and the WB result. It supports hold (stall) and bubble insertion (flush).

---
 rtl/id_ex_reg_pkg.sv | 30 +++
 rtl/id_ex_reg_if.sv | 72 +++++++
 rtl/id_ex_reg_fwd_sel.sv | 41 ++++
 rtl/id_ex_reg.sv | 127 ++++++++++++
 4 files changed

// File: rtl/id_ex_reg_pkg.sv
// ---------------------------------------------------------------------------
// id_ex_reg_pkg
// Shared constants and types for the ID/EX pipeline register and its
// EX-stage forwarding select generator.
//   - fwd_sel_t / FWD_* : encodings of the EX operand 4:1 mux select
//   - NOP_INSTR         : instruction word presented by a bubble or reset
//   - TNEW_W / tnew_t   : width of the Tnew ("cycles until result") field
//   - tnew_age()        : Tnew one stage later, saturating at zero
// ---------------------------------------------------------------------------
package id_ex_reg_pkg;

    localparam int TNEW_W = 2;

    typedef logic [1:0]        fwd_sel_t;
    typedef logic [TNEW_W-1:0] tnew_t;

    localparam fwd_sel_t FWD_REG = 2'b00;  // latched register-file value
    localparam fwd_sel_t FWD_MEM = 2'b01;  // MEM-stage result
    localparam fwd_sel_t FWD_WB  = 2'b10;  // WB-stage write data
    // 2'b11 is reserved and never produced.

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Tnew counts down by one per stage; a result that is already ready
    // (Tnew = 0) stays ready rather than wrapping.
    function automatic tnew_t tnew_age(input tnew_t t);
        return (t == '0) ? '0 : t - tnew_t'(1);
    endfunction

endpackage

// File: rtl/id_ex_reg_if.sv
// ---------------------------------------------------------------------------
// id_ex_reg_if
// Bundle between the ID stage / hazard unit and the ID/EX register.
//   stall, flush              : edge-sampled flow control
//   d_*                       : decoded instruction from ID
//   m_wr_addr, m_tnew         : MEM-stage destination and Tnew
//   w_wr_addr                 : WB-stage destination
//   e_valid, e_*              : latched instruction presented to EX
//   fwd_rs_sel, fwd_rt_sel    : EX operand mux selects
// Modports:
//   master : the surrounding pipeline (drives d_*/m_*/w_*, stall, flush)
//   slave  : the ID/EX register itself
// ---------------------------------------------------------------------------
interface id_ex_reg_if #(
    parameter int CTRL_W = 16
);
    import id_ex_reg_pkg::*;

    logic              stall;
    logic              flush;

    logic [31:0]       d_pc;
    logic [31:0]       d_instr;
    logic [31:0]       d_rs_data;
    logic [31:0]       d_rt_data;
    logic [31:0]       d_ext_imm;
    logic [4:0]        d_rs_addr;
    logic [4:0]        d_rt_addr;
    logic [4:0]        d_wr_addr;
    tnew_t             d_tnew;
    logic [CTRL_W-1:0] d_ctrl;

    logic [4:0]        m_wr_addr;
    tnew_t             m_tnew;
    logic [4:0]        w_wr_addr;

    logic              e_valid;
    logic [31:0]       e_pc;
    logic [31:0]       e_instr;
    logic [31:0]       e_rs_data;
    logic [31:0]       e_rt_data;
    logic [31:0]       e_ext_imm;
    logic [4:0]        e_rs_addr;
    logic [4:0]        e_rt_addr;
    logic [4:0]        e_wr_addr;
    tnew_t             e_tnew;
    logic [CTRL_W-1:0] e_ctrl;

    fwd_sel_t          fwd_rs_sel;
    fwd_sel_t          fwd_rt_sel;

    modport master (
        output stall, flush,
        output d_pc, d_instr, d_rs_data, d_rt_data, d_ext_imm,
        output d_rs_addr, d_rt_addr, d_wr_addr, d_tnew, d_ctrl,
        output m_wr_addr, m_tnew, w_wr_addr,
        input  e_valid, e_pc, e_instr, e_rs_data, e_rt_data, e_ext_imm,
        input  e_rs_addr, e_rt_addr, e_wr_addr, e_tnew, e_ctrl,
        input  fwd_rs_sel, fwd_rt_sel
    );

    modport slave (
        input  stall, flush,
        input  d_pc, d_instr, d_rs_data, d_rt_data, d_ext_imm,
        input  d_rs_addr, d_rt_addr, d_wr_addr, d_tnew, d_ctrl,
        input  m_wr_addr, m_tnew, w_wr_addr,
        output e_valid, e_pc, e_instr, e_rs_data, e_rt_data, e_ext_imm,
        output e_rs_addr, e_rt_addr, e_wr_addr, e_tnew, e_ctrl,
        output fwd_rs_sel, fwd_rt_sel
    );

endinterface

// File: rtl/id_ex_reg_fwd_sel.sv
// ---------------------------------------------------------------------------
// fwd_sel
// Combinational forwarding select for one EX source operand.
// Ports:
//   i_src_addr  : source register number latched in EX
//   i_m_wr_addr : MEM-stage destination register
//   i_m_tnew    : MEM-stage Tnew (0 = result available now)
//   i_w_wr_addr : WB-stage destination register
//   o_sel       : FWD_REG / FWD_MEM / FWD_WB
// MEM beats WB; $0 never forwards. A MEM match whose result is not yet
// ready blocks the WB path (the older WB value would be stale) and yields
// FWD_REG; the stall unit keeps EX from consuming that case.
// ---------------------------------------------------------------------------
module fwd_sel
    import id_ex_reg_pkg::*;
(
    input  logic [4:0] i_src_addr,
    input  logic [4:0] i_m_wr_addr,
    input  tnew_t      i_m_tnew,
    input  logic [4:0] i_w_wr_addr,
    output fwd_sel_t   o_sel
);

    logic w_src_live;
    logic w_m_hit;
    logic w_w_hit;

    assign w_src_live = (i_src_addr != 5'd0);
    assign w_m_hit    = w_src_live && (i_src_addr == i_m_wr_addr);
    assign w_w_hit    = w_src_live && (i_src_addr == i_w_wr_addr);

    always_comb begin
        o_sel = FWD_REG;
        if (w_m_hit) begin
            o_sel = (i_m_tnew == '0) ? FWD_MEM : FWD_REG;
        end else if (w_w_hit) begin
            o_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/id_ex_reg.sv
// ---------------------------------------------------------------------------
// id_ex_reg
// ID/EX pipeline register of the five-stage MIPS core plus the EX-stage
// forwarding select generator.
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous active-high reset (clears every register)
//   bus    : id_ex_reg_if.slave (stall/flush, d_*, m_*/w_*, e_*, selects)
// Edge priority: reset > stall > flush > load.
//   stall : everything holds (a simultaneous flush is dropped so the held
//           instruction still completes)
//   flush : bubble; only e_pc is loaded so the PC stays traceable
//   load  : all fields from d_*, e_valid=1, Tnew aged by one stage
// Configuration macro: ID_EX_FWD_EN
//   defined   : fwd_rs_sel / fwd_rt_sel from the MEM/WB match rules
//   undefined : both selects tied to FWD_REG; m_*/w_* inputs ignored
// ---------------------------------------------------------------------------
module id_ex_reg
    import id_ex_reg_pkg::*;
#(
    parameter int CTRL_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    id_ex_reg_if.slave  bus
);

    logic              r_valid;
    logic [31:0]       r_pc;
    logic [31:0]       r_instr;
    logic [31:0]       r_rs_data;
    logic [31:0]       r_rt_data;
    logic [31:0]       r_ext_imm;
    logic [4:0]        r_rs_addr;
    logic [4:0]        r_rt_addr;
    logic [4:0]        r_wr_addr;
    tnew_t             r_tnew;
    logic [CTRL_W-1:0] r_ctrl;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_pc      <= '0;
            r_instr   <= NOP_INSTR;
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_ext_imm <= '0;
            r_rs_addr <= '0;
            r_rt_addr <= '0;
            r_wr_addr <= '0;
            r_tnew    <= '0;
            r_ctrl    <= '0;
        end else if (bus.stall) begin
            // hold: no assignment
        end else if (bus.flush) begin
            // Zeroed source addresses force both selects back to FWD_REG.
            r_valid   <= 1'b0;
            r_pc      <= bus.d_pc;
            r_instr   <= NOP_INSTR;
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_ext_imm <= '0;
            r_rs_addr <= '0;
            r_rt_addr <= '0;
            r_wr_addr <= '0;
            r_tnew    <= '0;
            r_ctrl    <= '0;
        end else begin
            r_valid   <= 1'b1;
            r_pc      <= bus.d_pc;
            r_instr   <= bus.d_instr;
            r_rs_data <= bus.d_rs_data;
            r_rt_data <= bus.d_rt_data;
            r_ext_imm <= bus.d_ext_imm;
            r_rs_addr <= bus.d_rs_addr;
            r_rt_addr <= bus.d_rt_addr;
            r_wr_addr <= bus.d_wr_addr;
            r_tnew    <= tnew_age(bus.d_tnew);
            r_ctrl    <= bus.d_ctrl;
        end
    end

    assign bus.e_valid   = r_valid;
    assign bus.e_pc      = r_pc;
    assign bus.e_instr   = r_instr;
    assign bus.e_rs_data = r_rs_data;
    assign bus.e_rt_data = r_rt_data;
    assign bus.e_ext_imm = r_ext_imm;
    assign bus.e_rs_addr = r_rs_addr;
    assign bus.e_rt_addr = r_rt_addr;
    assign bus.e_wr_addr = r_wr_addr;
    assign bus.e_tnew    = r_tnew;
    assign bus.e_ctrl    = r_ctrl;

`ifdef ID_EX_FWD_EN
    // Index 0 = rs operand, index 1 = rt operand; identical rules.
    logic [4:0] w_src_addr [2];
    fwd_sel_t   w_sel      [2];

    assign w_src_addr[0] = r_rs_addr;
    assign w_src_addr[1] = r_rt_addr;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            fwd_sel u_fwd_sel (
                .i_src_addr  (w_src_addr[gi]),
                .i_m_wr_addr (bus.m_wr_addr),
                .i_m_tnew    (bus.m_tnew),
                .i_w_wr_addr (bus.w_wr_addr),
                .o_sel       (w_sel[gi])
            );
        end
    endgenerate

    assign bus.fwd_rs_sel = w_sel[0];
    assign bus.fwd_rt_sel = w_sel[1];
`else
    // Without forwarding the hazard unit stalls every RAW dependence, so
    // EX always reads the latched register value.
    assign bus.fwd_rs_sel = FWD_REG;
    assign bus.fwd_rt_sel = FWD_REG;

    logic w_unused_fwd_inputs;
    assign w_unused_fwd_inputs = ^{bus.m_wr_addr, bus.m_tnew, bus.w_wr_addr};
`endif

endmodule
